j_rxer: RTL
===========

// Module: j_rxer
// PURPOSE
//  Serial receiver for the Jerry UART: the receive half of the link driven by the UART transmitter.
//  Oversamples the serial input on the shared x16 baud enable.
//  Frames start + 8 data (LSB first) + optional parity + 1 stop, and presents the byte with status flags.
//  Sits beside the transmitter in the UART block.
//  Read by the CPU through the UART data/status registers.
// PARAMETERS
//  SYNC_STAGES  2  flops in the serin metastability synchroniser (>=2)
// PORTS
//  clk        in   1  system clock; all state on rising edge
//  resetl     in   1  asynchronous active-low reset
//  serin      in   1  raw serial input, asynchronous to clk
//  rxpol      in   1  1 = line inverted (sampled bit = serin ^ rxpol)
//  bx16       in   1  one-clk enable pulse at 16x baud rate
//  paren      in   1  1 = parity bit present and checked
//  even       in   1  1 = even parity, 0 = odd parity (ignored if paren=0)
//  u2drd      in   1  one-clk pulse: CPU read of receive data register
//  dout       out  8  last received byte
//  rbf        out  1  receive buffer full
//  perr       out  1  parity error on byte in dout
//  ferr       out  1  framing error (stop bit sampled 0) on byte in dout
//  ovr        out  1  overrun: a byte was loaded while rbf=1 (sticky)
// BEHAVIOUR
//  Reset: dout=0x00, rbf=perr=ferr=ovr=0, FSM=IDLE, counters=0, synchroniser preset to line idle (1).
//  Reset mid-frame discards the partial byte.
//  Input: rxd = synchronised(serin) ^ rxpol; 1 = mark/idle. Counters advance only on clk edges with bx16=1.
//  Counters: tick[3:0] (wraps 15->0), bitc[2:0], shift[7:0], par (running XOR).
//  FSM:
//   IDLE   : on bx16 with rxd=0 -> START, tick=0. Otherwise stay.
//   START  : on bx16, tick++; when tick reaches 7 (mid start bit):
//            rxd=0 -> DATA, tick=0, bitc=0, par=0.
//            rxd=1 -> IDLE (glitch rejected; no flags change).
//   DATA   : on bx16, tick++; at tick=15 sample rxd into shift[7] and shift right; par^=rxd.
//            bitc=7 at that sample -> PARITY if paren else STOP; else bitc++.
//   PARITY : at tick=15 sample p; perr_n = (par^p) != ~even.
//            even: total ones incl. p must be even; odd: must be odd. -> STOP.
//   STOP   : at tick=15 sample stop bit -> LOAD actions below, -> IDLE the same edge.
//            Next start edge is detectable from the following bx16.
//  LOAD (single clk, on the stop-sample edge):
//            dout<=shift, perr<=perr_n&paren, ferr<=~stop, rbf<=1.
//            If rbf was 1 and no u2drd this cycle: ovr<=1; dout is overwritten with the new byte.
//  u2drd: clears rbf and ovr next edge; perr/ferr hold until next LOAD.
//  Simultaneous LOAD and u2drd: rbf stays 1, ovr unchanged (not set), dout = new byte.
//  Latency: rbf rises on the clk edge of the stop-bit mid sample, about 9.5 bit times after the start edge (10.5 with parity).
//  bx16 stuck 0 freezes the FSM; bx16 stuck 1 is legal (baud = clk/16).
//  paren/even/rxpol are sampled live; software changes them only while idle.
//  Break (line held 0): receives 0x00 with ferr=1.
//  Then the FSM waits in IDLE for rxd=1 before a new start is accepted.
//  No other receptions occur during a continuous break.
// TESTING
//  1. paren=0, rxpol=0, bx16 every clk, send 0x55 with stop=1 -> dout=0x55, rbf=1, perr=ferr=ovr=0.
//  2. paren=1, even=1, send 0xA3 with parity bit 0 -> perr=0.
//     Repeat with parity bit 1 -> perr=1, dout=0xA3.
//  3. Send 0x3C with stop bit 0 -> ferr=1, rbf=1.
//     Then hold line 0 for 3 frames -> exactly one byte 0x00 with ferr=1; resumes after line returns to 1.
//  4. Low glitch of 4 bx16 ticks on idle line -> FSM back to IDLE, rbf stays 0, dout unchanged.
//  5. Receive 0x11 and 0x22 without u2drd -> dout=0x22, ovr=1.
//     Pulse u2drd -> rbf=0, ovr=0.
//     Pulse u2drd on the LOAD edge of a third byte -> rbf=1, ovr=0.
//  6. rxpol=1 with inverted line, send 0x81, and assert resetl low mid-DATA of a second byte -> 0x81 received.
//     After the reset: all outputs 0, no spurious byte.

Source files
------------

// File: rtl/j_rxer.sv
// Jerry UART receiver: start + 8 data (LSB first) + optional parity + stop, x16 oversampled.
// Latency: rbf rises on the stop-bit mid-sample edge (~9.5 bit times after start, 10.5 with parity).
// Backpressure: none; a byte landing while rbf=1 overwrites dout and sets sticky ovr.
module j_rxer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       resetl,
   input  logic       serin,
   input  logic       rxpol,
   input  logic       bx16,
   input  logic       paren,
   input  logic       even,
   input  logic       u2drd,
   output logic [7:0] dout,
   output logic       rbf,
   output logic       perr,
   output logic       ferr,
   output logic       ovr
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                 r_state, w_state_nx;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [3:0]             r_tick, w_tick_nx;
   logic [2:0]             r_bitc, w_bitc_nx;
   logic [7:0]             r_shift, w_shift_nx;
   logic                   r_par, w_par_nx;
   logic                   r_perr_n, w_perr_n_nx;
   logic                   r_wait, w_wait_nx;   // line must return to mark before next start
   logic                   w_load;
   logic                   w_rxd;
   logic [7:0]             r_dout;
   logic                   r_rbf, r_perr, r_ferr, r_ovr;

   assign w_rxd = r_sync[SYNC_STAGES-1] ^ rxpol;

   // Metastability synchroniser, preset to idle line level
   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) r_sync <= '1;
      else         r_sync <= {r_sync[SYNC_STAGES-2:0], serin};
   end

   // Framing state and bit counters
   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         r_state  <= S_IDLE;
         r_tick   <= '0;
         r_bitc   <= '0;
         r_shift  <= '0;
         r_par    <= 1'b0;
         r_perr_n <= 1'b0;
         r_wait   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_tick   <= w_tick_nx;
         r_bitc   <= w_bitc_nx;
         r_shift  <= w_shift_nx;
         r_par    <= w_par_nx;
         r_perr_n <= w_perr_n_nx;
         r_wait   <= w_wait_nx;
      end
   end

   // Next-state: everything advances only on bx16 ticks
   always_comb begin
      w_state_nx  = r_state;
      w_tick_nx   = r_tick;
      w_bitc_nx   = r_bitc;
      w_shift_nx  = r_shift;
      w_par_nx    = r_par;
      w_perr_n_nx = r_perr_n;
      w_wait_nx   = r_wait;
      w_load      = 1'b0;
      if (bx16) begin
         case (r_state)
            S_IDLE: begin
               if (w_rxd) begin
                  w_wait_nx = 1'b0;
               end else if (!r_wait) begin
                  w_state_nx = S_START;
                  w_tick_nx  = '0;
               end
            end
            S_START: begin
               w_tick_nx = r_tick + 4'd1;
               // Mid start bit: a line back at mark means it was only a glitch
               if (r_tick == 4'd6) begin
                  if (!w_rxd) begin
                     w_state_nx  = S_DATA;
                     w_tick_nx   = '0;
                     w_bitc_nx   = '0;
                     w_par_nx    = 1'b0;
                     w_perr_n_nx = 1'b0;
                  end else begin
                     w_state_nx = S_IDLE;
                  end
               end
            end
            S_DATA: begin
               w_tick_nx = r_tick + 4'd1;
               if (r_tick == 4'd15) begin
                  w_shift_nx = {w_rxd, r_shift[7:1]};
                  w_par_nx   = r_par ^ w_rxd;
                  if (r_bitc == 3'd7) w_state_nx = paren ? S_PARITY : S_STOP;
                  else                w_bitc_nx  = r_bitc + 3'd1;
               end
            end
            S_PARITY: begin
               w_tick_nx = r_tick + 4'd1;
               if (r_tick == 4'd15) begin
                  w_perr_n_nx = ((r_par ^ w_rxd) != ~even);
                  w_state_nx  = S_STOP;
               end
            end
            S_STOP: begin
               w_tick_nx = r_tick + 4'd1;
               if (r_tick == 4'd15) begin
                  w_load     = 1'b1;
                  w_state_nx = S_IDLE;
                  // A zero stop bit may be a break: hold off until the line returns to mark
                  w_wait_nx  = ~w_rxd;
               end
            end
            default: w_state_nx = S_IDLE;
         endcase
      end
   end

   // Receive buffer and status flags seen by the CPU
   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         r_dout <= '0;
         r_rbf  <= 1'b0;
         r_perr <= 1'b0;
         r_ferr <= 1'b0;
         r_ovr  <= 1'b0;
      end else if (w_load) begin
         r_dout <= r_shift;
         r_perr <= r_perr_n & paren;
         r_ferr <= ~w_rxd;
         r_rbf  <= 1'b1;
         // A read landing on the load edge consumes the old byte, so no overrun
         if (r_rbf && !u2drd) r_ovr <= 1'b1;
      end else if (u2drd) begin
         r_rbf <= 1'b0;
         r_ovr <= 1'b0;
      end
   end

   assign dout = r_dout;
   assign rbf  = r_rbf;
   assign perr = r_perr;
   assign ferr = r_ferr;
   assign ovr  = r_ovr;

endmodule
